// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter
// Round-robin arbiter and sequencer for a shared WIDTH-bit register bank.
// Each rising edge at most one requester's data is loaded into the bank, and
// a registered one-hot grant is returned for the following cycle. q_bar is
// the combinational complement of the bank and has no register of its own.
//
// Build option: define DFF_ARB_LOCK_EN to compile in burst ownership (OWNED
// state). Without it, the lock port is accepted but ignored, owner_valid and
// owner_id are tied to zero, and every edge is pure round-robin.
module dff_bank_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        q_bar,
    output logic                    owner_valid,
    output logic [IDW-1:0]          owner_id
);

    // NREQ expressed at the width used for wrap-around arithmetic.
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NREQ);

    // Bank contents, registered grant and round-robin priority pointer.
    logic [WIDTH-1:0] q_q,   q_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    // Result of the round-robin search in the current cycle.
    logic             win_found;
    logic [IDW-1:0]   win_idx;

`ifdef DFF_ARB_LOCK_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
`endif

    // (base + off) modulo NREQ, for base < NREQ and off < NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input logic [IDW:0]   off);
        logic [IDW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        return sum[IDW-1:0];
    endfunction

    // One-hot grant vector for requester idx.
    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        return {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Write-data slice belonging to requester idx.
    function automatic logic [WIDTH-1:0] slot(input logic [NREQ*WIDTH-1:0] data,
                                              input logic [IDW-1:0]        idx);
        return data[int'(idx) * WIDTH +: WIDTH];
    endfunction

    // Find the first set req bit in the order ptr, ptr+1, ..., wrapping to ptr-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req[wrap_add(ptr_q, (IDW + 1)'(k))]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, (IDW + 1)'(k));
            end
        end
    end

`ifdef DFF_ARB_LOCK_EN
    // Next-state logic: owner-only writes while OWNED, round-robin otherwise.
    always_comb begin
        q_d     = q_q;
        gnt_d   = '0;
        ptr_d   = ptr_q;
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ST_OWNED: begin
                // Other requesters are ignored and ptr stays put during a burst.
                if (req[owner_q]) begin
                    q_d   = slot(wdata, owner_q);
                    gnt_d = onehot(owner_q);
                end
                // Dropping lock ends the burst; a write on this edge still lands.
                if (!lock[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                if (win_found) begin
                    q_d   = slot(wdata, win_idx);
                    gnt_d = onehot(win_idx);
                    ptr_d = wrap_add(win_idx, (IDW + 1)'(1));
                    // lock is only looked at together with a grant.
                    if (lock[win_idx]) begin
                        state_d = ST_OWNED;
                        owner_d = win_idx;
                    end
                end
            end
        endcase
    end
`else
    // Next-state logic: pure round-robin on every edge.
    always_comb begin
        q_d   = q_q;
        gnt_d = '0;
        ptr_d = ptr_q;
        if (win_found) begin
            q_d   = slot(wdata, win_idx);
            gnt_d = onehot(win_idx);
            ptr_d = wrap_add(win_idx, (IDW + 1)'(1));
        end
    end
`endif

    // State registers; reset clears everything at once, including a burst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q     <= '0;
            gnt_q   <= '0;
            ptr_q   <= '0;
`ifdef DFF_ARB_LOCK_EN
            state_q <= ST_IDLE;
            owner_q <= '0;
`endif
        end else begin
            q_q     <= q_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
`ifdef DFF_ARB_LOCK_EN
            state_q <= state_d;
            owner_q <= owner_d;
`endif
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;
    assign gnt   = gnt_q;

`ifdef DFF_ARB_LOCK_EN
    assign owner_valid = (state_q == ST_OWNED);
    assign owner_id    = owner_q;
`else
    // lock has no effect in this build; fold it into a deliberately unused net.
    logic lock_unused;
    assign lock_unused = ^lock;
    assign owner_valid = 1'b0;
    assign owner_id    = '0;
`endif

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Testbench for dff_bank_arbiter: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the arbitration rules.
module tb_dff_bank_arbiter;

    localparam int WIDTH = 4;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
`ifdef DFF_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [WIDTH-1:0]      q_bar;
    logic                  owner_valid;
    logic [IDW-1:0]        owner_id;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state.
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt;
    int               m_ptr;
    bit               m_owned;
    int               m_owner;

    dff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .wdata       (wdata),
        .gnt         (gnt),
        .q           (q),
        .q_bar       (q_bar),
        .owner_valid (owner_valid),
        .owner_id    (owner_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] wd(input int i);
        return wdata[i*WIDTH +: WIDTH];
    endfunction

    task automatic set_wd(input int i, input logic [WIDTH-1:0] v);
        wdata[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic model_reset();
        m_q     = '0;
        m_gnt   = '0;
        m_ptr   = 0;
        m_owned = 1'b0;
        m_owner = 0;
    endtask

    // Apply one rising edge to the model using the inputs present at the edge.
    task automatic model_edge();
        bit found;
        m_gnt = '0;
        if (LOCK_EN && m_owned) begin
            if (req[m_owner]) begin
                m_q   = wd(m_owner);
                m_gnt = NREQ'(1) << m_owner;
            end
            if (!lock[m_owner]) m_owned = 1'b0;
        end else begin
            found = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (!found && req[i]) begin
                    found = 1'b1;
                    m_q   = wd(i);
                    m_gnt = NREQ'(1) << i;
                    m_ptr = (i + 1) % NREQ;
                    if (LOCK_EN && lock[i]) begin
                        m_owned = 1'b1;
                        m_owner = i;
                    end
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] exp_qb;
        exp_qb = ~m_q;
        chk({tag, ".q"},      q,     m_q);
        chk({tag, ".q_bar"},  q_bar, exp_qb);
        chk({tag, ".gnt"},    gnt,   m_gnt);
        chk({tag, ".ovalid"}, owner_valid, m_owned);
        if (m_owned) chk({tag, ".oid"}, owner_id, m_owner);
        chk({tag, ".gnt1hot"}, ($countones(gnt) <= 1), 1);
    endtask

    // One clock edge: model follows the DUT, outputs sampled 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset pulse placed between edges.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk({tag, ".q"},      q,           4'h0);
        chk({tag, ".q_bar"},  q_bar,       4'hF);
        chk({tag, ".gnt"},    gnt,         4'h0);
        chk({tag, ".ovalid"}, owner_valid, 1'b0);
        chk({tag, ".oid"},    owner_id,    2'd0);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [NREQ-1:0]  rr_gnt [5];
        logic [WIDTH-1:0] rr_q   [5];
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_q   = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};

        req   = '0;
        lock  = '0;
        wdata = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        model_reset();
        chk("rst.q",      q,           4'h0);
        chk("rst.q_bar",  q_bar,       4'hF);
        chk("rst.gnt",    gnt,         4'h0);
        chk("rst.ovalid", owner_valid, 1'b0);
        chk("rst.oid",    owner_id,    2'd0);
        @(negedge clk);
        reset = 1'b1;

        // Single request from requester 2.
        req = 4'b0100;
        set_wd(2, 4'hA);
        step("single");
        chk("single.q",     q,     4'hA);
        chk("single.q_bar", q_bar, 4'h5);
        chk("single.gnt",   gnt,   4'b0100);
        req = '0;
        step("single_drop");
        chk("single_drop.gnt", gnt, 4'b0000);
        // ptr is now 3: with everyone requesting, requester 3 wins first.
        req = 4'b1111;
        step("ptr3");
        chk("ptr3.gnt", gnt, 4'b1000);
        req = '0;

        // Async reset with q = 0xA.
        req = 4'b0001;
        set_wd(0, 4'hA);
        step("pre_arst");
        chk("pre_arst.q", q, 4'hA);
        req = '0;
        async_reset("arst");

        // Round-robin fairness from ptr = 0.
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_wd(i, WIDTH'(i + 1));
        for (int k = 0; k < 5; k++) begin
            step("rr");
            chk("rr.gnt_seq", gnt, rr_gnt[k]);
            chk("rr.q_seq",   q,   rr_q[k]);
        end
        req = '0;

        // Lock burst: req0+lock0 for 3 edges, req1 throughout.
        async_reset("arst2");
        set_wd(0, 4'h7);
        set_wd(1, 4'h9);
        req  = 4'b0011;
        lock = 4'b0001;
        step("burst0");
        chk("burst0.gnt", gnt, 4'b0001);
        for (int k = 0; k < 2; k++) step("burst");
        req  = 4'b0010;
        lock = 4'b0000;
        for (int k = 0; k < 3; k++) step("burst_exit");
        req = '0;

        // Reset mid-burst with owner 2.
        req  = 4'b0100;
        lock = 4'b0100;
        step("own2");
        req  = 4'b0100;
        step("own2_hold");
        async_reset("arst_burst");
        req  = 4'b1111;
        lock = '0;
        step("post_rst");
        chk("post_rst.gnt", gnt, 4'b0001);
        req = '0;

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            req   = NREQ'($urandom);
            lock  = NREQ'($urandom) & NREQ'($urandom);
            wdata = (NREQ*WIDTH)'($urandom);
            step("rand");
            if ($urandom_range(0, 39) == 0) async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and sequencer for a shared WIDTH-bit D-flip-flop register bank that several requesters write.
- Each clock edge it selects at most one requester, loads that requester's data into the bank and returns a one-cycle grant.
- An optional lock lets one requester own the bank for a multi-cycle burst.
- It sits between the requester logic and the shared bank, and drives the bank's true and complemented outputs.

## Interface
- WIDTH, 4: bank width in bits.
- NREQ, 4: number of requesters, 2..8.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester write request; bit i belongs to requester i.
- lock  in  NREQ  per-requester ownership hold; used only with DFF_ARB_LOCK_EN.
- wdata  in  NREQ*WIDTH  write data; slice [i*WIDTH +: WIDTH] belongs to requester i.
- gnt  out  NREQ  registered one-hot grant; high for the cycle after the data was captured.
- q  out  WIDTH  bank contents.
- q_bar  out  WIDTH  always ~q.
- owner_valid  out  1  high while a requester owns the bank (state OWNED).
- owner_id  out  clog2(NREQ), min 1  index of the current owner; valid only when owner_valid=1.

## Operation
- Reset (reset=0, no clock needed): state=IDLE, ptr=0, q=0, q_bar=all ones, gnt=0, owner_valid=0, owner_id=0.
- ptr is the highest-priority index. The search order is ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
- IDLE, rising edge with any req bit high:
  - winner w = first set req bit in search order.
  - q <= wdata[w], gnt <= onehot(w).
  - ptr <= (w==NREQ-1) ? 0 : w+1.
  - if lock[w]=1, state <= OWNED and owner_id <= w.
- IDLE, edge with req=0: gnt <= 0; q, ptr and state hold.
- OWNED, every edge:
  - if req[owner]=1: q <= wdata[owner], gnt <= onehot(owner); otherwise gnt <= 0 and q holds.
  - req bits of all other requesters are ignored; ptr holds.
  - if lock[owner]=0 on that edge, state <= IDLE. The write still happens on that edge if req[owner]=1.
- Requester protocol:
  - hold req and wdata stable until gnt is seen.
  - drop req in the gnt cycle unless another write is wanted.
  - a req still high when gnt is seen is re-arbitrated as a new request. Fairness still holds because ptr has moved past the requester.
- gnt has at most one bit set, and never while reset=0.
- q_bar is combinational ~q and is never independently registered.

## Timing
- Write latency: req and wdata sampled at edge E → q valid after E; gnt high from E to E+1.
- Throughput: one write per cycle.
- Starvation bound: a requester holding req is granted within NREQ edges in IDLE, plus the length of any lock burst in progress.
- Reset assertion: outputs go to reset values immediately, mid-burst included; the lock is lost.
- Reset release: the first arbitration happens on the first rising edge with reset=1.
- lock is sampled only together with a grant (entry) or on OWNED edges (exit). lock without req never enters OWNED.

## Configuration
- DFF_ARB_LOCK_EN defined: OWNED state and lock behaviour as above.
- DFF_ARB_LOCK_EN undefined:
  - lock port is present but ignored; state is always IDLE.
  - owner_valid is tied to 0 and owner_id to 0.
  - every edge is pure round-robin.

## Test plan
- Async reset: drive q=0xA, pull reset low between edges → q=0x0, q_bar=0xF, gnt=0 immediately, before any clock edge.
- Single request: req=0100, wdata[2]=0xA for one edge → q=0xA, q_bar=0x5, gnt=0100 for exactly one cycle, ptr=3.
- Round-robin fairness: req=1111 held, wdata[i]=i+1 → gnt sequence 0001,0010,0100,1000,0001; q sequence 1,2,3,4,1.
- Lock burst (DFF_ARB_LOCK_EN):
  - stimulus: req0 and lock0 high for 3 edges, req1 high throughout.
  - response: gnt=0001 for 3 consecutive cycles, owner_valid=1, owner_id=0; then gnt=0010 after lock0 drops.
- Reset mid-burst: reset low while OWNED with owner 2 → owner_valid=0, ptr=0; after release with req=1111, first gnt=0001.
- Lock compiled out: same stimulus as the lock burst → gnt alternates 0001,0010; owner_valid stays 0.
